// File: rtl/rpn_cpu_core.sv
// Parametrised RPN calculator CPU datapath: executes one ROM instruction per step strobe,
// with a register file, event-driven flag register and a CALL/RET return-address stack.
module rpn_cpu_core #(
    parameter int DATA_W      = 8,
    parameter int NREG        = 32,
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            step,
    input  logic [3:0]                      evt,
    input  logic [DATA_W-1:0]               din,
    input  logic [11+2*DATA_W+ADDR_W-1:0]   instr,
    output logic [ADDR_W-1:0]               ip,
    output logic [DATA_W-1:0]               dout,
    output logic [DATA_W-1:0]               gpo,
    output logic [DATA_W-1:0]               flags
);
    localparam int RA_W = $clog2(NREG);
    localparam int SP_W = $clog2(STACK_DEPTH + 1);
    localparam int ST_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [RA_W-1:0] FLAG_A = RA_W'(NREG - 1);
    localparam logic [RA_W-1:0] DOUT_A = RA_W'(NREG - 2);
    localparam logic [RA_W-1:0] GPO_A  = RA_W'(NREG - 3);
    localparam logic [RA_W-1:0] DIN_A  = RA_W'(NREG - 4);
    localparam int OFLW_B = 4;
    localparam int SHFT_B = 5;
    localparam int STKERR_B = 6;

    logic [DATA_W-1:0] regs_q  [NREG];
    logic [DATA_W-1:0] regs_d  [NREG];
    logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
    logic [ADDR_W-1:0] stack_d [STACK_DEPTH];
    logic [ADDR_W-1:0] ip_q, ip_d;
    logic [SP_W-1:0]   sp_q, sp_d;

    logic [3:0]        grp;
    logic [2:0]        cmd;
    logic [1:0]        t1, t2;
    logic [DATA_W-1:0] a1, a2;
    logic [ADDR_W-1:0] addr;
    assign {grp, cmd, t1, a1, t2, a2, addr} = instr;

    // Operand fetch: direct and one-level-indirect reads for both argument slots.
    logic [DATA_W-1:0] r1_dir, r1_ind, r2_dir, r2_ind, num1, num2, acc;
    logic [RA_W-1:0]   loc1, loc2;
    assign r1_dir = regs_q[a1[RA_W-1:0]];
    assign r1_ind = regs_q[r1_dir[RA_W-1:0]];
    assign r2_dir = regs_q[a2[RA_W-1:0]];
    assign r2_ind = regs_q[r2_dir[RA_W-1:0]];
    assign num1 = (t1 == 2'd1) ? r1_dir : (t1 == 2'd2) ? r1_ind : a1;
    assign num2 = (t2 == 2'd1) ? r2_dir : (t2 == 2'd2) ? r2_ind : a2;
    assign loc1 = (t1 == 2'd1) ? a1[RA_W-1:0] : (t1 == 2'd2) ? r1_dir[RA_W-1:0] : '0;
    assign loc2 = (t2 == 2'd1) ? a2[RA_W-1:0] : (t2 == 2'd2) ? r2_dir[RA_W-1:0] : '0;
    assign acc  = regs_q[loc1];

    logic [DATA_W:0]          usum;
    logic signed [DATA_W:0]   ssum;
    logic [2*DATA_W-1:0]      uprod;
    logic signed [2*DATA_W-1:0] sprod;
    logic sad_ovf, smt_ovf;
    assign usum  = {1'b0, acc} + {1'b0, num2};
    assign ssum  = $signed({acc[DATA_W-1], acc}) + $signed({num2[DATA_W-1], num2});
    assign uprod = {{DATA_W{1'b0}}, acc} * {{DATA_W{1'b0}}, num2};
    assign sprod = $signed({{DATA_W{acc[DATA_W-1]}}, acc}) * $signed({{DATA_W{num2[DATA_W-1]}}, num2});
    assign sad_ovf = ssum[DATA_W] ^ ssum[DATA_W-1];
    // Signed product fits only if the upper half plus the result sign bit are all equal.
    assign smt_ovf = ~((&sprod[2*DATA_W-1:DATA_W-1]) | ~(|sprod[2*DATA_W-1:DATA_W-1]));

    logic [DATA_W-1:0] cmd_mask;
    logic [ADDR_W-1:0] ip_inc;
    logic              take;
    assign cmd_mask = DATA_W'(1) << cmd;
    assign ip_inc   = ip_q + ADDR_W'(1);

    always_comb begin
        unique case (cmd)
            3'd0:    take = 1'b1;
            3'd1:    take = (num1 == num2);
            3'd2:    take = (num1 < num2);
            3'd3:    take = ($signed(num1) < $signed(num2));
            3'd4:    take = (num1 <= num2);
            3'd5:    take = ($signed(num1) <= $signed(num2));
            default: take = 1'b0;
        endcase
    end

    always_comb begin
        regs_d  = regs_q;
        stack_d = stack_q;
        ip_d    = ip_q;
        sp_d    = sp_q;
        if (step) begin
            ip_d = ip_inc;
            case (grp)
                4'd1: begin
                    case (cmd)
                        3'd1: begin
                            regs_d[loc2] = num1 << 1;
                            regs_d[FLAG_A][SHFT_B] = num1[DATA_W-1];
                        end
                        3'd2: begin
                            regs_d[loc2] = num1 >> 1;
                            regs_d[FLAG_A][SHFT_B] = num1[0];
                        end
                        default: regs_d[loc2] = num1;
                    endcase
                end
                4'd2: if (take) ip_d = addr;
                4'd3: begin
                    case (cmd)
                        3'd0: begin
                            regs_d[loc1] = usum[DATA_W-1:0];
                            regs_d[FLAG_A][OFLW_B] = usum[DATA_W];
                        end
                        3'd1: begin
                            regs_d[loc1] = ssum[DATA_W-1:0];
                            regs_d[FLAG_A][OFLW_B] = sad_ovf;
                        end
                        3'd2: begin
                            regs_d[loc1] = uprod[DATA_W-1:0];
                            regs_d[FLAG_A][OFLW_B] = |uprod[2*DATA_W-1:DATA_W];
                        end
                        3'd3: begin
                            regs_d[loc1] = sprod[DATA_W-1:0];
                            regs_d[FLAG_A][OFLW_B] = smt_ovf;
                        end
                        3'd4: regs_d[loc1] = acc & num2;
                        3'd5: regs_d[loc1] = acc | num2;
                        3'd6: regs_d[loc1] = acc ^ num2;
                        default: ;
                    endcase
                end
                4'd4: begin
                    if (|(regs_q[FLAG_A] & cmd_mask)) ip_d = addr;
                    regs_d[FLAG_A] = regs_q[FLAG_A] & ~cmd_mask;
                end
                4'd5: begin
                    if (cmd == 3'd0) begin
                        if (sp_q < SP_W'(STACK_DEPTH)) begin
                            stack_d[ST_W'(sp_q)] = ip_inc;
                            sp_d = sp_q + SP_W'(1);
                            ip_d = addr;
                        end else begin
                            regs_d[FLAG_A][STKERR_B] = 1'b1;
                        end
                    end else if (cmd == 3'd1) begin
                        if (sp_q != '0) begin
                            ip_d = stack_q[ST_W'(sp_q - SP_W'(1))];
                            sp_d = sp_q - SP_W'(1);
                        end else begin
                            regs_d[FLAG_A][STKERR_B] = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
        // Event strobes land after the instruction so they beat any same-cycle write.
        for (int j = 0; j < 4; j++) begin
            if (evt[j]) regs_d[FLAG_A][j] = 1'b1;
        end
        if (evt[3]) regs_d[DIN_A] = din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ip_q <= '0;
            sp_q <= '0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
        end else begin
            ip_q <= ip_d;
            sp_q <= sp_d;
            for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
            for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= stack_d[i];
        end
    end

    assign ip    = ip_q;
    assign dout  = regs_q[DOUT_A];
    assign gpo   = regs_q[GPO_A];
    assign flags = regs_q[FLAG_A];
endmodule

// File: tb/tb_rpn_cpu_core.sv
// Bench for rpn_cpu_core: directed scenarios plus random instructions against an integer model.
module tb_rpn_cpu_core;
    localparam int IW_A = 11 + 2*8 + 8;
    localparam int IW_W = 11 + 2*12 + 8;

    logic            clk = 1'b0;
    logic            reset = 1'b0, step = 1'b0;
    logic [3:0]      evt = '0;
    logic [7:0]      din = '0;
    logic [IW_A-1:0] instr = '0;
    logic [7:0]      ip, dout, gpo, flags;

    logic            reset_w = 1'b0, step_w = 1'b0;
    logic [3:0]      evt_w = '0;
    logic [11:0]     din_w = '0;
    logic [IW_W-1:0] instr_w = '0;
    logic [7:0]      ip_w;
    logic [11:0]     dout_w, gpo_w, flags_w;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rpn_cpu_core #(.DATA_W(8), .NREG(32), .ADDR_W(8), .STACK_DEPTH(2)) dut (
        .clk(clk), .reset(reset), .step(step), .evt(evt), .din(din), .instr(instr),
        .ip(ip), .dout(dout), .gpo(gpo), .flags(flags));

    rpn_cpu_core #(.DATA_W(12), .NREG(64), .ADDR_W(8), .STACK_DEPTH(4)) dut_w (
        .clk(clk), .reset(reset_w), .step(step_w), .evt(evt_w), .din(din_w), .instr(instr_w),
        .ip(ip_w), .dout(dout_w), .gpo(gpo_w), .flags(flags_w));

    // Reference model: plain integers, a queue for the return stack.
    int m_reg[32];
    int m_ip;
    int m_stk[$];

    function automatic int sx(input int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    function automatic int m_num(input int t, input int a);
        if (t == 1) return m_reg[a % 32];
        if (t == 2) return m_reg[m_reg[a % 32] % 32];
        return a;
    endfunction

    function automatic int m_loc(input int t, input int a);
        if (t == 1) return a % 32;
        if (t == 2) return m_reg[a % 32] % 32;
        return 0;
    endfunction

    task automatic m_setbit(input int b, input bit v);
        if (v) m_reg[31] = m_reg[31] | (1 << b);
        else   m_reg[31] = m_reg[31] & ~(1 << b);
    endtask

    task automatic model_cycle(input logic rst, input logic stp, input logic [3:0] ev,
                               input logic [7:0] di, input logic [IW_A-1:0] ins);
        int grp, cmd, t1, a1, t2, a2, ad, x, y, r, full, nip;
        bit tk;
        if (rst) begin
            foreach (m_reg[i]) m_reg[i] = 0;
            m_ip = 0;
            m_stk.delete();
            return;
        end
        if (stp) begin
            grp = int'(ins[34:31]); cmd = int'(ins[30:28]);
            t1 = int'(ins[27:26]);  a1 = int'(ins[25:18]);
            t2 = int'(ins[17:16]);  a2 = int'(ins[15:8]);
            ad = int'(ins[7:0]);
            nip = (m_ip + 1) % 256;
            case (grp)
                1: begin
                    x = m_num(t1, a1); r = m_loc(t2, a2);
                    if (cmd == 1) begin m_reg[r] = (x * 2) % 256; m_setbit(5, x >= 128); end
                    else if (cmd == 2) begin m_reg[r] = x / 2; m_setbit(5, (x % 2) == 1); end
                    else m_reg[r] = x;
                end
                2: begin
                    x = m_num(t1, a1); y = m_num(t2, a2);
                    case (cmd)
                        0: tk = 1;
                        1: tk = (x == y);
                        2: tk = (x < y);
                        3: tk = (sx(x) < sx(y));
                        4: tk = (x <= y);
                        5: tk = (sx(x) <= sx(y));
                        default: tk = 0;
                    endcase
                    if (tk) nip = ad;
                end
                3: begin
                    r = m_loc(t1, a1); y = m_num(t2, a2); x = m_reg[r];
                    case (cmd)
                        0: begin full = x + y; m_reg[r] = full % 256; m_setbit(4, full > 255); end
                        1: begin full = sx(x) + sx(y); m_reg[r] = full & 255; m_setbit(4, full < -128 || full > 127); end
                        2: begin full = x * y; m_reg[r] = full % 256; m_setbit(4, full > 255); end
                        3: begin full = sx(x) * sx(y); m_reg[r] = full & 255; m_setbit(4, full < -128 || full > 127); end
                        4: m_reg[r] = x & y;
                        5: m_reg[r] = x | y;
                        6: m_reg[r] = x ^ y;
                        default: ;
                    endcase
                end
                4: begin
                    if (((m_reg[31] >> cmd) & 1) == 1) nip = ad;
                    m_setbit(cmd, 0);
                end
                5: begin
                    if (cmd == 0) begin
                        if (m_stk.size() < 2) begin m_stk.push_back(nip); nip = ad; end
                        else m_setbit(6, 1);
                    end else if (cmd == 1) begin
                        if (m_stk.size() > 0) nip = m_stk.pop_back();
                        else m_setbit(6, 1);
                    end
                end
                default: ;
            endcase
            m_ip = nip;
        end
        for (int j = 0; j < 4; j++) if (ev[j]) m_setbit(j, 1);
        if (ev[3]) m_reg[28] = int'(di);
    endtask

    function automatic logic [IW_A-1:0] mk(input int g, input int c, input int ta, input int aa,
                                           input int tb, input int ab, input int ad);
        logic [IW_A-1:0] v;
        v = {4'(g), 3'(c), 2'(ta), 8'(aa), 2'(tb), 8'(ab), 8'(ad)};
        return v;
    endfunction

    function automatic logic [IW_W-1:0] mk_w(input int g, input int c, input int ta, input int aa,
                                             input int tb, input int ab, input int ad);
        logic [IW_W-1:0] v;
        v = {4'(g), 3'(c), 2'(ta), 12'(aa), 2'(tb), 12'(ab), 8'(ad)};
        return v;
    endfunction

    task automatic drive(input logic rst, input logic stp, input logic [3:0] ev,
                         input logic [7:0] di, input logic [IW_A-1:0] ins);
        @(negedge clk);
        reset = rst; step = stp; evt = ev; din = di; instr = ins;
        @(posedge clk);
        model_cycle(rst, stp, ev, di, ins);
        #1;
        reset = 1'b0; step = 1'b0; evt = '0;
        $display("[TB] rst=%0b step=%0b evt=%h instr=%h -> ip=%0d dout=%h gpo=%h flags=%h",
                 rst, stp, ev, ins, ip, dout, gpo, flags);
    endtask

    task automatic drive_w(input logic rst, input logic [IW_W-1:0] ins);
        @(negedge clk);
        reset_w = rst; step_w = 1'b1; instr_w = ins;
        @(posedge clk);
        #1;
        reset_w = 1'b0; step_w = 1'b0;
        $display("[TB] wide rst=%0b instr=%h -> ip=%0d gpo=%h flags=%h", rst, ins, ip_w, gpo_w, flags_w);
    endtask

    task automatic test_reset;
        drive(1'b1, 1'b1, 4'hF, 8'h55, mk(1, 0, 0, 8'h77, 1, 30, 0));
        n_tests++; if (ip !== 8'd0)    begin n_fail++; $display("FAIL reset_ip got=%h exp=00", ip); end
        n_tests++; if (dout !== 8'd0)  begin n_fail++; $display("FAIL reset_dout got=%h exp=00", dout); end
        n_tests++; if (gpo !== 8'd0)   begin n_fail++; $display("FAIL reset_gpo got=%h exp=00", gpo); end
        n_tests++; if (flags !== 8'd0) begin n_fail++; $display("FAIL reset_flags got=%h exp=00", flags); end
    endtask

    task automatic test_mov;
        drive(1'b1, 1'b0, 4'h0, 8'h00, '0);
        drive(1'b0, 1'b1, 4'h0, 8'h00, mk(1, 0, 0, 8'hA5, 1, 30, 0));
        n_tests++; if (dout !== 8'hA5) begin n_fail++; $display("FAIL mov_dout got=%h exp=a5", dout); end
        n_tests++; if (ip !== 8'd1)    begin n_fail++; $display("FAIL mov_ip got=%h exp=01", ip); end
    endtask

    task automatic test_acc;
        drive(1'b0, 1'b1, 4'h0, 8'h00, mk(1, 0, 0, 200, 1, 2, 0));
        drive(1'b0, 1'b1, 4'h0, 8'h00, mk(3, 0, 1, 2, 0, 100, 0));
        drive(1'b0, 1'b1, 4'h0, 8'h00, mk(1, 0, 1, 2, 1, 30, 0));
        n_tests++; if (dout !== 8'd44) begin n_fail++; $display("FAIL uad_result got=%h exp=2c", dout); end
        n_tests++; if (flags[4] !== 1'b1) begin n_fail++; $display("FAIL uad_oflw got=%b exp=1", flags[4]); end
        drive(1'b0, 1'b1, 4'h0, 8'h00, mk(1, 0, 0, 100, 1, 2, 0));
        drive(1'b0, 1'b1, 4'h0, 8'h00, mk(3, 1, 1, 2, 0, 100, 0));
        drive(1'b0, 1'b1, 4'h0, 8'h00, mk(1, 0, 1, 2, 1, 30, 0));
        n_tests++; if (dout !== 8'hC8) begin n_fail++; $display("FAIL sad_pos_result got=%h exp=c8", dout); end
        n_tests++; if (flags[4] !== 1'b1) begin n_fail++; $display("FAIL sad_pos_oflw got=%b exp=1", flags[4]); end
        drive(1'b0, 1'b1, 4'h0, 8'h00, mk(1, 0, 0, 8'hFD, 1, 2, 0));
        drive(1'b0, 1'b1, 4'h0, 8'h00, mk(3, 1, 1, 2, 0, 5, 0));
        drive(1'b0, 1'b1, 4'h0, 8'h00, mk(1, 0, 1, 2, 1, 30, 0));
        n_tests++; if (dout !== 8'h02) begin n_fail++; $display("FAIL sad_neg_result got=%h exp=02", dout); end
        n_tests++; if (flags[4] !== 1'b0) begin n_fail++; $display("FAIL sad_neg_oflw got=%b exp=0", flags[4]); end
    endtask

    task automatic test_shift;
        drive(1'b0, 1'b1, 4'h0, 8'h00, mk(1, 1, 0, 8'h81, 1, 30, 0));
        n_tests++; if (dout !== 8'h02) begin n_fail++; $display("FAIL shl_result got=%h exp=02", dout); end
        n_tests++; if (flags[5] !== 1'b1) begin n_fail++; $display("FAIL shl_shft got=%b exp=1", flags[5]); end
        drive(1'b0, 1'b1, 4'h0, 8'h00, mk(1, 2, 0, 8'h02, 1, 30, 0));
        n_tests++; if (dout !== 8'h01) begin n_fail++; $display("FAIL shr_result got=%h exp=01", dout); end
        n_tests++; if (flags[5] !== 1'b0) begin n_fail++; $display("FAIL shr_shft got=%b exp=0", flags[5]); end
    endtask

    task automatic test_atc;
        drive(1'b1, 1'b0, 4'h0, 8'h00, '0);
        drive(1'b0, 1'b1, 4'b1000, 8'h3C, mk(4, 3, 0, 0, 0, 0, 8'h77));
        n_tests++; if (flags[3] !== 1'b1) begin n_fail++; $display("FAIL atc_evt_flag got=%b exp=1", flags[3]); end
        n_tests++; if (ip !== 8'd1) begin n_fail++; $display("FAIL atc_nojump_ip got=%h exp=01", ip); end
        drive(1'b0, 1'b1, 4'h0, 8'h00, mk(1, 0, 1, 28, 1, 30, 0));
        n_tests++; if (dout !== 8'h3C) begin n_fail++; $display("FAIL din_capture got=%h exp=3c", dout); end
        drive(1'b0, 1'b1, 4'h0, 8'h00, mk(4, 3, 0, 0, 0, 0, 8'h77));
        n_tests++; if (ip !== 8'h77) begin n_fail++; $display("FAIL atc_jump_ip got=%h exp=77", ip); end
        n_tests++; if (flags[3] !== 1'b0) begin n_fail++; $display("FAIL atc_clear got=%b exp=0", flags[3]); end
        drive(1'b0, 1'b0, 4'b0001, 8'h00, mk(2, 0, 0, 0, 0, 0, 8'h33));
        n_tests++; if (ip !== 8'h77) begin n_fail++; $display("FAIL idle_ip got=%h exp=77", ip); end
        n_tests++; if (flags[0] !== 1'b1) begin n_fail++; $display("FAIL idle_evt got=%b exp=1", flags[0]); end
        drive(1'b0, 1'b1, 4'b0001, 8'h00, mk(4, 0, 0, 0, 0, 0, 8'h10));
        n_tests++; if (ip !== 8'h10) begin n_fail++; $display("FAIL atc_evt_jump got=%h exp=10", ip); end
        n_tests++; if (flags[0] !== 1'b1) begin n_fail++; $display("FAIL atc_evt_wins got=%b exp=1", flags[0]); end
    endtask

    task automatic test_jmp;
        drive(1'b1, 1'b0, 4'h0, 8'h00, '0);
        drive(1'b0, 1'b1, 4'h0, 8'h00, mk(2, 3, 0, 8'hFF, 0, 1, 9));
        n_tests++; if (ip !== 8'd9) begin n_fail++; $display("FAIL jmp_slt got=%h exp=09", ip); end
        drive(1'b0, 1'b1, 4'h0, 8'h00, mk(2, 2, 0, 8'hFF, 0, 1, 30));
        n_tests++; if (ip !== 8'd10) begin n_fail++; $display("FAIL jmp_ult got=%h exp=0a", ip); end
        drive(1'b0, 1'b1, 4'h0, 8'h00, mk(2, 6, 0, 0, 0, 0, 30));
        n_tests++; if (ip !== 8'd11) begin n_fail++; $display("FAIL jmp_never got=%h exp=0b", ip); end
        drive(1'b0, 1'b1, 4'h0, 8'h00, mk(2, 5, 0, 5, 0, 5, 50));
        n_tests++; if (ip !== 8'd50) begin n_fail++; $display("FAIL jmp_sle got=%h exp=32", ip); end
    endtask

    task automatic test_stack;
        drive(1'b1, 1'b0, 4'h0, 8'h00, '0);
        drive(1'b0, 1'b1, 4'h0, 8'h00, mk(2, 0, 0, 0, 0, 0, 5));
        drive(1'b0, 1'b1, 4'h0, 8'h00, mk(5, 0, 0, 0, 0, 0, 20));
        n_tests++; if (ip !== 8'd20) begin n_fail++; $display("FAIL call1_ip got=%0d exp=20", ip); end
        drive(1'b0, 1'b1, 4'h0, 8'h00, mk(5, 0, 0, 0, 0, 0, 40));
        n_tests++; if (ip !== 8'd40) begin n_fail++; $display("FAIL call2_ip got=%0d exp=40", ip); end
        drive(1'b0, 1'b1, 4'h0, 8'h00, mk(5, 0, 0, 0, 0, 0, 99));
        n_tests++; if (ip !== 8'd41) begin n_fail++; $display("FAIL call_full_ip got=%0d exp=41", ip); end
        n_tests++; if (flags[6] !== 1'b1) begin n_fail++; $display("FAIL call_full_err got=%b exp=1", flags[6]); end
        drive(1'b0, 1'b1, 4'h0, 8'h00, mk(5, 1, 0, 0, 0, 0, 0));
        n_tests++; if (ip !== 8'd21) begin n_fail++; $display("FAIL ret1_ip got=%0d exp=21", ip); end
        drive(1'b0, 1'b1, 4'h0, 8'h00, mk(5, 1, 0, 0, 0, 0, 0));
        n_tests++; if (ip !== 8'd6) begin n_fail++; $display("FAIL ret2_ip got=%0d exp=6", ip); end
        drive(1'b0, 1'b1, 4'h0, 8'h00, mk(5, 1, 0, 0, 0, 0, 0));
        n_tests++; if (ip !== 8'd7) begin n_fail++; $display("FAIL ret_empty_ip got=%0d exp=7", ip); end
        n_tests++; if (flags[6] !== 1'b1) begin n_fail++; $display("FAIL ret_empty_err got=%b exp=1", flags[6]); end
    endtask

    task automatic test_random;
        int hot[7] = '{2, 3, 27, 28, 29, 30, 31};
        int a1, a2;
        logic [3:0] ev;
        for (int n = 0; n < 400; n++) begin
            a1 = ($urandom_range(0, 1) == 1) ? hot[$urandom_range(0, 6)] + 32 * $urandom_range(0, 7) : $urandom_range(0, 255);
            a2 = ($urandom_range(0, 1) == 1) ? hot[$urandom_range(0, 6)] + 32 * $urandom_range(0, 7) : $urandom_range(0, 255);
            for (int j = 0; j < 4; j++) ev[j] = ($urandom_range(0, 15) == 0);
            drive($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, ev, 8'($urandom),
                  mk($urandom_range(0, 6), $urandom_range(0, 7), $urandom_range(0, 3), a1,
                     $urandom_range(0, 3), a2, $urandom_range(0, 255)));
            n_tests++; if (ip !== 8'(m_ip)) begin n_fail++; $display("FAIL rand_ip[%0d] got=%h exp=%h", n, ip, 8'(m_ip)); end
            n_tests++; if (dout !== 8'(m_reg[30])) begin n_fail++; $display("FAIL rand_dout[%0d] got=%h exp=%h", n, dout, 8'(m_reg[30])); end
            n_tests++; if (gpo !== 8'(m_reg[29])) begin n_fail++; $display("FAIL rand_gpo[%0d] got=%h exp=%h", n, gpo, 8'(m_reg[29])); end
            n_tests++; if (flags !== 8'(m_reg[31])) begin n_fail++; $display("FAIL rand_flags[%0d] got=%h exp=%h", n, flags, 8'(m_reg[31])); end
        end
    endtask

    task automatic test_wide;
        drive_w(1'b1, '0);
        drive_w(1'b0, mk_w(1, 0, 0, 4095, 1, 61, 0));
        drive_w(1'b0, mk_w(3, 2, 1, 61, 0, 2, 0));
        n_tests++; if (gpo_w !== 12'd4094) begin n_fail++; $display("FAIL umt_wide got=%0d exp=4094", gpo_w); end
        n_tests++; if (flags_w[4] !== 1'b1) begin n_fail++; $display("FAIL umt_wide_oflw got=%b exp=1", flags_w[4]); end
        drive_w(1'b0, mk_w(1, 0, 0, 63, 1, 10, 0));
        drive_w(1'b0, mk_w(1, 0, 0, 12'h0A5, 2, 10, 0));
        n_tests++; if (flags_w !== 12'h0A5) begin n_fail++; $display("FAIL indirect_flag got=%h exp=0a5", flags_w); end
        n_tests++; if (ip_w !== 8'd4) begin n_fail++; $display("FAIL wide_ip got=%0d exp=4", ip_w); end
    endtask

    initial begin
        test_reset;
        test_mov;
        test_acc;
        test_shift;
        test_atc;
        test_jmp;
        test_stack;
        test_random;
        test_wide;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
